// File: rtl/jacaranda_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jacaranda_loader_pkg
//  Purpose  : Shared state encoding and SPI flash constants for the
//             Jacaranda-8 flash boot loader.
//  Revision : 1.0 - initial release
// ============================================================================
package jacaranda_loader_pkg;

    // Standard SPI flash READ opcode (no dummy cycles)
    localparam logic [7:0] SPI_CMD_READ = 8'h03;

    // Opcode plus 24-bit address
    localparam int SPI_CMD_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_CMD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_DESELECT = 3'd4,
        ST_DONE     = 3'd5
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/jacaranda_spi_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : jacaranda_spi_shifter
//  Purpose  : SCK divider (SPI mode 0) and a shared 32-bit shift register.
//             In transmit mode the MSB drives MOSI and shifts on SCK falls;
//             in receive mode MISO shifts in on SCK rises.  Emits a strobe
//             on every SCK fall and on every eighth received bit.
//  Revision : 1.0 - initial release
// ============================================================================
module jacaranda_spi_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        load,
    input  logic        tx_mode,
    input  logic [31:0] load_word,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        bit_done,
    output logic        byte_done,
    output logic [7:0]  rx_byte
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_sck;
    logic [31:0]      r_sr;
    logic [2:0]       r_rx_cnt;
    logic             w_tick;
    logic             w_rise;
    logic             w_fall;

    assign w_tick = run && (r_div == c_div_last);
    assign w_rise = w_tick && !r_sck;
    assign w_fall = w_tick && r_sck;

    // SCK divider: each SCK phase lasts CLK_DIV cycles, starting low
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            r_div <= '0;
            r_sck <= 1'b0;
        end else if (w_tick) begin
            r_div <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Shift register: TX moves out on falls, RX captures MISO on rises
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr     <= '0;
            r_rx_cnt <= '0;
        end else if (load) begin
            r_sr     <= load_word;
            r_rx_cnt <= '0;
        end else if (tx_mode && w_fall) begin
            r_sr     <= {r_sr[30:0], 1'b0};
        end else if (!tx_mode && w_rise) begin
            r_sr     <= {r_sr[30:0], miso};
            r_rx_cnt <= r_rx_cnt + 1'b1;
        end
    end

    // Gate SCK with run so it drops the moment the loader stops the clock
    assign sck       = r_sck & run;
    assign mosi      = tx_mode & r_sr[31];
    assign bit_done  = w_fall;
    assign byte_done = !tx_mode && w_rise && (r_rx_cnt == 3'd7);
    assign rx_byte   = {r_sr[6:0], miso};

endmodule
`default_nettype wire

// File: rtl/jacaranda_flash_loader.sv
`default_nettype none
// ============================================================================
//  Module   : jacaranda_flash_loader
//  Purpose  : Boot sequencer: reads LOAD_LEN bytes from SPI flash starting at
//             FLASH_BASE, writes them to CPU instruction memory and holds the
//             Jacaranda-8 in reset until the image is in place.
//  Options  : JACARANDA_LOADER_CSUM_EN - modulo-256 image checksum on csum_o
//  Revision : 1.0 - initial release
// ============================================================================
module jacaranda_flash_loader
    import jacaranda_loader_pkg::*;
#(
    parameter logic [23:0] FLASH_BASE = 24'h010000,
    parameter int          LOAD_LEN   = 256,
    parameter int          ADDR_W     = 8,
    parameter int          CLK_DIV    = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    output logic              flash_csb_o,
    output logic              flash_clk_o,
    output logic              flash_io0_o,
    input  logic              flash_io1_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [7:0]        imem_wdata_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [7:0]        csum_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
    // One extra bit so a full 2**ADDR_W image terminates before wrapping
    localparam logic [ADDR_W:0]  c_last_idx = (ADDR_W + 1)'(LOAD_LEN - 1);
    localparam logic [31:0]      c_cmd_word = {SPI_CMD_READ, FLASH_BASE};

    loader_state_t    r_state;
    loader_state_t    w_next;
    logic [DIV_W-1:0] r_tmr;
    logic [4:0]       r_bits;
    logic [ADDR_W:0]  r_cnt;
    logic             r_we;
    logic [7:0]       r_wdata;
    logic             w_start;
    logic             w_run;
    logic             w_tx;
    logic             w_csb;
    logic             w_bit_done;
    logic             w_byte_done;
    logic [7:0]       w_rx_byte;

    // A start request is honoured only when no load is in flight
    assign w_start = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // FSM state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Per-state cycle timer (CS setup/hold) and command bit counter
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tmr  <= '0;
            r_bits <= '0;
        end else begin
            r_tmr  <= (w_next != r_state) ? '0 : r_tmr + 1'b1;
            if (r_state != ST_CMD) r_bits <= '0;
            else if (w_bit_done)   r_bits <= r_bits + 1'b1;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        w_next    = r_state;
        w_run     = 1'b0;
        w_tx      = 1'b0;
        w_csb     = 1'b1;
        busy_o    = 1'b1;
        done_o    = 1'b0;
        cpu_rst_o = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) w_next = ST_SELECT;
            end
            ST_SELECT: begin
                w_csb = 1'b0;
                w_tx  = 1'b1;
                if (r_tmr == c_div_last) w_next = ST_CMD;
            end
            ST_CMD: begin
                w_csb = 1'b0;
                w_tx  = 1'b1;
                w_run = 1'b1;
                if (w_bit_done && (r_bits == 5'(SPI_CMD_BITS - 1))) w_next = ST_DATA;
            end
            ST_DATA: begin
                w_csb = 1'b0;
                w_run = 1'b1;
                if (r_we && (r_cnt == c_last_idx)) w_next = ST_DESELECT;
            end
            ST_DESELECT: begin
                if (r_tmr == c_div_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                busy_o    = 1'b0;
                done_o    = 1'b1;
                cpu_rst_o = 1'b0;
                if (start_i) w_next = ST_SELECT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Reset deselects the flash without waiting for the clock edge
    assign flash_csb_o = w_csb | wb_rst_i;

    jacaranda_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .run       (w_run),
        .load      (w_start),
        .tx_mode   (w_tx),
        .load_word (c_cmd_word),
        .miso      (flash_io1_i),
        .sck       (flash_clk_o),
        .mosi      (flash_io0_o),
        .bit_done  (w_bit_done),
        .byte_done (w_byte_done),
        .rx_byte   (w_rx_byte)
    );

    // One-cycle memory write per received byte; address advances after it
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_we <= w_byte_done;
            if (w_byte_done) r_wdata <= w_rx_byte;
            if (w_start)     r_cnt   <= '0;
            else if (r_we)   r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign imem_we_o    = r_we;
    assign imem_addr_o  = r_cnt[ADDR_W-1:0];
    assign imem_wdata_o = r_wdata;

`ifdef JACARANDA_LOADER_CSUM_EN
    logic [7:0] r_csum;

    // Running modulo-256 sum, updated alongside each memory write
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || w_start) r_csum <= '0;
        else if (w_byte_done)    r_csum <= r_csum + w_rx_byte;
    end

    assign csum_o = r_csum;
`else
    assign csum_o = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jacaranda_flash_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jacaranda_flash_loader
//  Purpose  : Self-checking bench: two loader instances (256 bytes / CLK_DIV 2
//             and 1 byte / CLK_DIV 1) against behavioural SPI flash models.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jacaranda_flash_loader;

`ifdef JACARANDA_LOADER_CSUM_EN
    localparam logic [7:0] EXP_CSUM_A = 8'h80;
    localparam logic [7:0] EXP_CSUM_B = 8'hA5;
`else
    localparam logic [7:0] EXP_CSUM_A = 8'h00;
    localparam logic [7:0] EXP_CSUM_B = 8'h00;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_start, a_csb, a_sck, a_mosi, a_miso, a_we;
    logic       a_cpu_rst, a_busy, a_done;
    logic [7:0] a_addr, a_wdata, a_csum;
    logic       b_rst, b_start, b_csb, b_sck, b_mosi, b_miso, b_we;
    logic       b_cpu_rst, b_busy, b_done;
    logic [7:0] b_addr, b_wdata, b_csum;

    jacaranda_flash_loader #(
        .FLASH_BASE (24'h010000), .LOAD_LEN (256), .ADDR_W (8), .CLK_DIV (2)
    ) dut_a (
        .wb_clk_i (clk), .wb_rst_i (a_rst), .start_i (a_start),
        .flash_csb_o (a_csb), .flash_clk_o (a_sck), .flash_io0_o (a_mosi),
        .flash_io1_i (a_miso), .imem_we_o (a_we), .imem_addr_o (a_addr),
        .imem_wdata_o (a_wdata), .cpu_rst_o (a_cpu_rst), .busy_o (a_busy),
        .done_o (a_done), .csum_o (a_csum)
    );

    jacaranda_flash_loader #(
        .FLASH_BASE (24'h010000), .LOAD_LEN (1), .ADDR_W (8), .CLK_DIV (1)
    ) dut_b (
        .wb_clk_i (clk), .wb_rst_i (b_rst), .start_i (b_start),
        .flash_csb_o (b_csb), .flash_clk_o (b_sck), .flash_io0_o (b_mosi),
        .flash_io1_i (b_miso), .imem_we_o (b_we), .imem_addr_o (b_addr),
        .imem_wdata_o (b_wdata), .cpu_rst_o (b_cpu_rst), .busy_o (b_busy),
        .done_o (b_done), .csum_o (b_csum)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Flash image: image A holds byte k at 0x010000+k; image B holds 0xA5 at 0x010000
    function automatic logic flash_bit(input logic [23:0] addr, input int n, input bit img_b);
        logic [23:0] a;
        logic [7:0]  d;
        a = addr + 24'(n / 8);
        if (img_b) d = (a == 24'h010000) ? 8'hA5 : 8'hFF;
        else       d = 8'(a - 24'h010000);
        return d[7 - (n % 8)];
    endfunction

    // Flash model A: command captured on SCK rises, data driven on SCK falls
    logic [31:0] a_cmd = '0;
    int          a_rise = 0;
    int          a_dbit = 0;
    always @(posedge a_sck or posedge a_csb) begin
        if (a_csb) a_rise <= 0;
        else begin
            if (a_rise < 32) a_cmd <= {a_cmd[30:0], a_mosi};
            a_rise <= a_rise + 1;
        end
    end
    always @(negedge a_sck or posedge a_csb) begin
        if (a_csb) begin
            a_dbit <= 0;
            a_miso <= 1'b0;
        end else if (a_rise >= 32) begin
            a_miso <= flash_bit(a_cmd[23:0], a_dbit, 1'b0);
            a_dbit <= a_dbit + 1;
        end
    end

    // Flash model B
    logic [31:0] b_cmd = '0;
    int          b_rise = 0;
    int          b_dbit = 0;
    always @(posedge b_sck or posedge b_csb) begin
        if (b_csb) b_rise <= 0;
        else begin
            if (b_rise < 32) b_cmd <= {b_cmd[30:0], b_mosi};
            b_rise <= b_rise + 1;
        end
    end
    always @(negedge b_sck or posedge b_csb) begin
        if (b_csb) begin
            b_dbit <= 0;
            b_miso <= 1'b0;
        end else if (b_rise >= 32) begin
            b_miso <= flash_bit(b_cmd[23:0], b_dbit, 1'b1);
            b_dbit <= b_dbit + 1;
        end
    end

    // Scoreboards: {addr, data} pushed when a load is started
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int   a_wr = 0, b_wr = 0, a_done_rises = 0, a_cs_win = 0, a_mosi_viol = 0;
    logic a_prev_done = 1'b0, a_prev_csb = 1'b1, a_prev_sck = 1'b0, a_prev_mosi = 1'b0;

    always @(negedge clk) begin
        a_prev_done <= a_done;
        a_prev_csb  <= a_csb;
        a_prev_sck  <= a_sck;
        a_prev_mosi <= a_mosi;
        if (a_done && !a_prev_done) a_done_rises <= a_done_rises + 1;
        if (!a_csb && a_prev_csb)   a_cs_win <= a_cs_win + 1;
        if (a_sck && a_prev_sck && (a_mosi != a_prev_mosi)) a_mosi_viol <= a_mosi_viol + 1;
        if (a_we) begin
            a_wr <= a_wr + 1;
            if (qa.size() == 0) check_eq("a_unexpected_write", 32'(a_we), 32'd0);
            else begin
                check_eq("a_wr_addr", 32'(a_addr), 32'(qa[0][15:8]));
                check_eq("a_wr_data", 32'(a_wdata), 32'(qa[0][7:0]));
                qa.delete(0);
            end
        end
    end

    always @(negedge clk) begin
        if (b_we) begin
            b_wr <= b_wr + 1;
            if (qb.size() == 0) check_eq("b_unexpected_write", 32'(b_we), 32'd0);
            else begin
                check_eq("b_wr_addr", 32'(b_addr), 32'(qb[0][15:8]));
                check_eq("b_wr_data", 32'(b_wdata), 32'(qb[0][7:0]));
                qb.delete(0);
            end
        end
    end

    task automatic push_a_load();
        for (int i = 0; i < 256; i++) qa.push_back({8'(i), 8'(i)});
    endtask

    task automatic pulse_a_start();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_a_done();
        int n = 0;
        while (!a_done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq("a_done_reached", 32'(a_done), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_a_released(input string tag, input int base);
        check_eq({tag, "_writes"},  32'(a_wr - base), 32'd256);
        check_eq({tag, "_q_empty"}, 32'(qa.size()), 32'd0);
        check_eq({tag, "_cpu_rst"}, 32'(a_cpu_rst), 32'd0);
        check_eq({tag, "_busy"},    32'(a_busy), 32'd0);
        check_eq({tag, "_csb"},     32'(a_csb), 32'd1);
        check_eq({tag, "_mosi"},    32'(a_mosi), 32'd0);
        check_eq({tag, "_csum"},    32'(a_csum), 32'(EXP_CSUM_A));
    endtask

    int base, rises0, win0, lat;

    initial begin
        a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("a_rst_ctrl", {a_csb, a_sck, a_mosi, a_we, a_cpu_rst, a_busy, a_done},
                 {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        check_eq("a_rst_data", {a_addr, a_wdata, a_csum}, 24'h0);
        check_eq("b_rst_ctrl", {b_csb, b_sck, b_mosi, b_we, b_cpu_rst, b_busy, b_done},
                 {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);

        // B: single byte at CLK_DIV=1, latency 1+1+(32+8)*2+1 = 83 cycles +-1
        qb.push_back({8'h00, 8'hA5});
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        lat = 0;
        while (!b_done && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        check_eq("b_done_reached", 32'(b_done), 32'd1);
        check_eq("b_latency_in_window", 32'((lat >= 82) && (lat <= 84)), 32'd1);
        check_eq("b_cpu_rst", 32'(b_cpu_rst), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("b_writes", 32'(b_wr), 32'd1);
        check_eq("b_q_empty", 32'(qb.size()), 32'd0);
        check_eq("b_csum", 32'(b_csum), 32'(EXP_CSUM_B));
        check_eq("b_cmd_word", b_cmd, 32'h03010000);

        // A: full 256-byte load with an ignored start on cycle 100
        base = a_wr; rises0 = a_done_rises; win0 = a_cs_win;
        push_a_load();
        pulse_a_start();
        check_eq("a_busy_after_start", 32'(a_busy), 32'd1);
        repeat (98) @(negedge clk);
        pulse_a_start();
        check_eq("a_busy_mid_load", 32'(a_busy), 32'd1);
        wait_a_done();
        check_a_released("a_load1", base);
        check_eq("a_cmd_word", a_cmd, 32'h03010000);
        check_eq("a_mosi_stable_sck_high", 32'(a_mosi_viol), 32'd0);
        check_eq("a_done_rises", 32'(a_done_rises - rises0), 32'd1);
        check_eq("a_cs_windows", 32'(a_cs_win - win0), 32'd1);

        // A: start while DONE reloads; reset and done change with SELECT entry
        base = a_wr;
        push_a_load();
        pulse_a_start();
        check_eq("a_reload_cpu_rst", 32'(a_cpu_rst), 32'd1);
        check_eq("a_reload_done", 32'(a_done), 32'd0);
        check_eq("a_reload_csb", 32'(a_csb), 32'd0);
        wait_a_done();
        check_a_released("a_load2", base);

        // A: reset after the 10th write abandons the load
        base = a_wr;
        push_a_load();
        pulse_a_start();
        lat = 0;
        while ((a_wr - base) < 10 && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        check_eq("a_ten_writes", 32'(a_wr - base), 32'd10);
        a_rst = 1'b1;
        qa.delete();
        @(negedge clk);
        check_eq("a_midrst_ctrl", {a_csb, a_sck, a_we, a_cpu_rst, a_busy, a_done},
                 {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        check_eq("a_midrst_addr", 32'(a_addr), 32'd0);
        a_rst = 1'b0;
        base = a_wr;
        repeat (300) @(negedge clk);
        check_eq("a_no_writes_after_rst", 32'(a_wr - base), 32'd0);
        check_eq("a_idle_after_rst", {a_csb, a_busy, a_cpu_rst}, {1'b1, 1'b0, 1'b1});

        push_a_load();
        pulse_a_start();
        wait_a_done();
        check_a_released("a_load3", base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jacaranda_flash_loader.md
Name: jacaranda_flash_loader

Overview:
- Boot sequencer in the user project area.
- Reads the Jacaranda-8 program image from the external SPI flash over mprj_io pins, using a READ command (0x03) followed by a 24-bit address.
- Writes each received byte into the CPU instruction memory.
- Holds the CPU in reset until the whole image is loaded, then releases it.

Parameters:
- FLASH_BASE, 24'h010000, flash byte address of the first image byte
- LOAD_LEN, 256, number of bytes to load (1..256)
- ADDR_W, 8, instruction memory address width
- CLK_DIV, 2, SCK half-period in wb_clk_i cycles (>=1)

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- start_i  in  1  single-cycle load request
- flash_csb_o  out  1  flash chip select, active low
- flash_clk_o  out  1  SCK, SPI mode 0
- flash_io0_o  out  1  MOSI
- flash_io1_i  in  1  MISO
- imem_we_o  out  1  instruction memory write strobe
- imem_addr_o  out  ADDR_W  instruction memory write address
- imem_wdata_o  out  8  instruction byte
- cpu_rst_o  out  1  Jacaranda-8 reset, active high
- busy_o  out  1  load in progress
- done_o  out  1  image loaded, sticky
- csum_o  out  8  image checksum (see Optional Feature)

Behaviour:
- Reset values: flash_csb_o=1, flash_clk_o=0, flash_io0_o=0, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, cpu_rst_o=1, busy_o=0, done_o=0, csum_o=0. FSM in IDLE.
- FSM states: IDLE, SELECT, CMD, DATA, DESELECT, DONE.
- IDLE:
  - start_i=1 -> SELECT.
  - busy_o=1 from the next cycle.
  - cpu_rst_o stays 1.
- SELECT:
  - flash_csb_o=0.
  - Held for CLK_DIV cycles (CS setup), then -> CMD.
- CMD:
  - Shifts out 32 bits MSB-first: 0x03, then FLASH_BASE[23:0].
  - flash_io0_o changes only while SCK is low.
  - SCK high for CLK_DIV cycles, low for CLK_DIV cycles.
  - After the 32nd falling edge -> DATA. SCK keeps running with no gap.
- DATA:
  - flash_io1_i is sampled on the wb_clk_i edge where SCK goes 0->1.
  - Bits form a byte MSB-first.
  - On the cycle after the 8th sample of a byte:
    - imem_we_o=1 for exactly one cycle
    - imem_wdata_o = the byte
    - imem_addr_o = byte index, starting at 0, incrementing by 1 after each write
  - SCK is not stalled for the write.
  - After byte LOAD_LEN-1 is written -> DESELECT. SCK returns low.
- DESELECT:
  - flash_csb_o=1 for CLK_DIV cycles, then -> DONE.
- DONE:
  - busy_o=0, done_o=1, cpu_rst_o=0 (all on the same cycle).
  - flash_io0_o=0.
- start_i handling:
  - Ignored while busy_o=1.
  - start_i in DONE begins a reload: same cycle as the transition to SELECT, cpu_rst_o=1 and done_o=0; imem_addr_o restarts at 0.
- Address wrap: LOAD_LEN=256 with ADDR_W=8 -> last write at address 0xFF. The counter is ADDR_W+1 bits wide, so it does not wrap before termination.
- wb_rst_i asserted mid-load: all outputs return to reset values on the next edge. flash_csb_o goes high immediately. A partially loaded image is abandoned. No automatic restart.
- Nominal latency, start_i to done_o: 1 + CLK_DIV + (32 + 8*LOAD_LEN)*2*CLK_DIV + CLK_DIV cycles, ±1 cycle.

Optional Feature:
- Macro: JACARANDA_LOADER_CSUM_EN.
- Defined:
  - csum_o is an 8-bit modulo-256 sum of all bytes written this load.
  - Cleared on each start and on reset.
  - Updated in the same cycle as imem_we_o.
  - Valid when done_o=1.
- Undefined: csum_o is tied to 0 and the adder is absent.

Decomposition:
- Package jacaranda_loader_pkg:
  - FSM state encoding (typedef)
  - SPI_CMD_READ = 8'h03
  - command length of 32 bits
- Sub-module jacaranda_spi_shifter:
  - SCK divider plus bidirectional 8/32-bit shift register
  - Emits bit_done and byte_done strobes
  - Controlled by the loader FSM

Test Plan:
- Flash model loaded with bytes 0x00..0xFF at 0x010000; LOAD_LEN=256, CLK_DIV=2; pulse start_i -> 256 imem writes, address i gets data i, and a single CS-low window. Then done_o=1, cpu_rst_o=0, csum_o=0x80 with macro, 0 without.
- Probe MOSI during CMD -> the 32 bits captured on SCK rising edges equal 0x03010000. flash_io0_o is stable whenever SCK is high.
- Pulse start_i again on cycle 100 of a load -> no effect; write count stays 256 and there is exactly one done_o rising edge.
- Assert wb_rst_i for 1 cycle after the 10th write -> next edge: flash_csb_o=1, cpu_rst_o=1, busy_o=0, no further writes. A following start_i produces a full reload starting at address 0.
- LOAD_LEN=1, CLK_DIV=1; flash byte 0xA5 -> one write of 0xA5 at address 0. Latency equals the formula ±1 cycle.
- start_i while in DONE -> cpu_rst_o=1 and done_o=0 on the same cycle as SELECT is entered, then a full reload and release again.
